// File: rtl/hacd_pkg.sv
// Shared HACD/Hawk AXI4 widths, packet types and byte-lane helpers.
// Also holds the write-master FSM state type and AXI encodings.
package hacd_pkg;

   localparam int HACD_AXI4_ID_WIDTH   = 4;
   localparam int HACD_AXI4_ADDR_WIDTH = 40;
   localparam int HACD_AXI4_LEN_WIDTH  = 8;
   localparam int HACD_AXI4_DATA_WIDTH = 512;
   localparam int HACD_AXI4_RESP_WIDTH = 2;
   localparam int HACD_AXI4_STRB_WIDTH = HACD_AXI4_DATA_WIDTH / 8;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
   localparam logic [HACD_AXI4_RESP_WIDTH-1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [HACD_AXI4_DATA_WIDTH-1:0] data;
      logic [HACD_AXI4_STRB_WIDTH-1:0] strb;
      logic                            awvalid;
      logic                            wvalid;
   } axi_wr_reqpkt_t;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [HACD_AXI4_DATA_WIDTH-1:0] data;
      logic [HACD_AXI4_STRB_WIDTH-1:0] strb;
   } axi_wr_pld_t;

   typedef struct packed {
      logic awready;
      logic wready;
   } axi_wr_rdypkt_t;

   typedef struct packed {
      logic bvalid;
      logic bresp;
   } axi_wr_resppkt_t;

   typedef enum logic [1:0] {
      AXIWR_IDLE      = 2'd0,
      AXIWR_ADDR_DATA = 2'd1,
      AXIWR_WAIT_B    = 2'd2,
      AXIWR_RESP      = 2'd3
   } hawk_axiwr_state_t;

   // Reverse byte order inside every 64-bit word of the cacheline.
   function automatic logic [HACD_AXI4_DATA_WIDTH-1:0] get_8byte_byteswap(
      input logic [HACD_AXI4_DATA_WIDTH-1:0] data
   );
      logic [HACD_AXI4_DATA_WIDTH-1:0] swapped;
      swapped = '0;
      for (int w = 0; w < HACD_AXI4_DATA_WIDTH / 64; w++) begin
         for (int b = 0; b < 8; b++) begin
            swapped[w*64 + b*8 +: 8] = data[w*64 + (7-b)*8 +: 8];
         end
      end
      return swapped;
   endfunction

   function automatic logic [HACD_AXI4_STRB_WIDTH-1:0] get_strb_swap(
      input logic [HACD_AXI4_STRB_WIDTH-1:0] strb
   );
      logic [HACD_AXI4_STRB_WIDTH-1:0] swapped;
      swapped = '0;
      for (int w = 0; w < HACD_AXI4_STRB_WIDTH / 8; w++) begin
         for (int b = 0; b < 8; b++) begin
            swapped[w*8 + b] = strb[w*8 + 7 - b];
         end
      end
      return swapped;
   endfunction

endpackage

// File: rtl/hawk_axiwr_master.sv
// Single-outstanding AXI4 write master: one 64-byte cacheline per request,
// issued as a single-beat burst, with a B-channel watchdog.
module hawk_axiwr_master
   import hacd_pkg::*;
#(
   parameter int AXI_ID    = 0,
   parameter int B_TIMEOUT = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_i,

   input  axi_wr_reqpkt_t                    req_i,
   output axi_wr_rdypkt_t                    rdy_o,
   output axi_wr_resppkt_t                   resp_o,

   output logic [HACD_AXI4_ID_WIDTH-1:0]     m_axi_awid,
   output logic [HACD_AXI4_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [HACD_AXI4_LEN_WIDTH-1:0]    m_axi_awlen,
   output logic [2:0]                        m_axi_awsize,
   output logic [1:0]                        m_axi_awburst,
   output logic [3:0]                        m_axi_awcache,
   output logic [2:0]                        m_axi_awprot,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,

   output logic [HACD_AXI4_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [HACD_AXI4_STRB_WIDTH-1:0]   m_axi_wstrb,
   output logic                              m_axi_wlast,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,

   input  logic [HACD_AXI4_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [HACD_AXI4_RESP_WIDTH-1:0]   m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,

   output logic                              err_timeout_o,
   output logic                              err_resp_o,
   output logic [31:0]                       wr_cnt_o
);

   localparam int WDOG_W = (B_TIMEOUT > 2) ? $clog2(B_TIMEOUT) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(B_TIMEOUT - 1);
   localparam logic [HACD_AXI4_ID_WIDTH-1:0] AXI_ID_L = HACD_AXI4_ID_WIDTH'(AXI_ID);

   hawk_axiwr_state_t state_reg;
   hawk_axiwr_state_t state_next;

   axi_wr_pld_t         pld_reg;
   logic                aw_done_reg;
   logic                w_done_reg;
   logic [WDOG_W-1:0]   wdog_cnt_reg;
   logic                err_reg;
   logic                err_timeout_reg;
   logic                err_resp_reg;
   logic [31:0]         wr_cnt_reg;

   logic accept;
   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic b_err;
   logic wdog_expired;

   assign accept       = (state_reg == AXIWR_IDLE) & req_i.awvalid & req_i.wvalid;
   assign aw_hs        = m_axi_awvalid & m_axi_awready;
   assign w_hs         = m_axi_wvalid & m_axi_wready;
   assign b_hs         = m_axi_bvalid & m_axi_bready;
   assign b_err        = (m_axi_bresp != AXI_RESP_OKAY) | (m_axi_bid != AXI_ID_L);
   assign wdog_expired = (wdog_cnt_reg == WDOG_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= AXIWR_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         AXIWR_IDLE: begin
            if (accept) begin
               state_next = AXIWR_ADDR_DATA;
            end
         end
         AXIWR_ADDR_DATA: begin
            if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) begin
               state_next = AXIWR_WAIT_B;
            end
         end
         AXIWR_WAIT_B: begin
            if (b_hs | wdog_expired) begin
               state_next = AXIWR_RESP;
            end
         end
         AXIWR_RESP: begin
            state_next = AXIWR_IDLE;
         end
         default: state_next = AXIWR_IDLE;
      endcase
   end

   // bready stays high in IDLE so a late B after a timeout is drained silently.
   always_comb begin
      rdy_o         = '0;
      resp_o        = '0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      unique case (state_reg)
         AXIWR_IDLE: begin
            rdy_o.awready = 1'b1;
            rdy_o.wready  = 1'b1;
            m_axi_bready  = 1'b1;
         end
         AXIWR_ADDR_DATA: begin
            m_axi_awvalid = ~aw_done_reg;
            m_axi_wvalid  = ~w_done_reg;
         end
         AXIWR_WAIT_B: begin
            m_axi_bready = 1'b1;
         end
         AXIWR_RESP: begin
            resp_o.bvalid = 1'b1;
            resp_o.bresp  = err_reg;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pld_reg         <= '0;
         aw_done_reg     <= 1'b0;
         w_done_reg      <= 1'b0;
         wdog_cnt_reg    <= '0;
         err_reg         <= 1'b0;
         err_timeout_reg <= 1'b0;
         err_resp_reg    <= 1'b0;
         wr_cnt_reg      <= '0;
      end else begin
         unique case (state_reg)
            AXIWR_IDLE: begin
               if (accept) begin
                  pld_reg.addr <= req_i.addr;
                  pld_reg.data <= get_8byte_byteswap(req_i.data);
                  pld_reg.strb <= get_strb_swap(req_i.strb);
                  aw_done_reg  <= 1'b0;
                  w_done_reg   <= 1'b0;
               end
            end
            AXIWR_ADDR_DATA: begin
               if (aw_hs) begin
                  aw_done_reg <= 1'b1;
               end
               if (w_hs) begin
                  w_done_reg <= 1'b1;
               end
               wdog_cnt_reg <= '0;
            end
            AXIWR_WAIT_B: begin
               wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
               // A response landing in the expiry cycle takes priority.
               if (b_hs) begin
                  err_reg <= b_err;
                  if (b_err) begin
                     err_resp_reg <= 1'b1;
                  end
               end else if (wdog_expired) begin
                  err_reg         <= 1'b1;
                  err_timeout_reg <= 1'b1;
               end
            end
            AXIWR_RESP: begin
               wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign m_axi_awid    = AXI_ID_L;
   assign m_axi_awaddr  = pld_reg.addr;
   assign m_axi_awlen   = '0;
   assign m_axi_awsize  = AXI_SIZE_64B;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awcache = AXI_CACHE_BUF_MOD;
   assign m_axi_awprot  = 3'b000;

   assign m_axi_wdata   = pld_reg.data;
   assign m_axi_wstrb   = pld_reg.strb;
   assign m_axi_wlast   = 1'b1;

   assign err_timeout_o = err_timeout_reg;
   assign err_resp_o    = err_resp_reg;
   assign wr_cnt_o      = wr_cnt_reg;

endmodule
